// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared constants and lock state type for arb_mux
package arb_mux_pkg;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and stall-gated pointer
module rr_arbiter #(
  parameter int PORT = 4,
  parameter int IDX  = $clog2(PORT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PORT-1:0] req,
  input  logic            stall,
  output logic [PORT-1:0] granto
);

  localparam int SLOTS = 1 << IDX;

  logic [IDX-1:0]   ptr;
  logic [IDX-1:0]   grant_idx;
  logic [IDX-1:0]   idx;
  logic [SLOTS-1:0] req_pad;
  logic [SLOTS-1:0] grant_pad;
  logic             found;

  // Search wraps over the full power-of-two index space; padded slots never request.
  always_comb begin
    req_pad            = '0;
    req_pad[PORT-1:0]  = req;
    grant_pad          = '0;
    grant_idx          = '0;
    found              = 1'b0;
    idx                = '0;
    for (int i = 0; i < SLOTS; i++) begin
      idx = ptr + IDX'(i);
      if (!found && req_pad[idx]) begin
        found          = 1'b1;
        grant_idx      = idx;
        grant_pad[idx] = 1'b1;
      end
    end
  end

  assign granto = stall ? '0 : grant_pad[PORT-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (!stall && found) begin
      ptr <= grant_idx + IDX'(1);
    end
  end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N:1 round-robin arbitrated mux with registered output and packet lock
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int PORT = 4,
  parameter int DATA = 32,
  parameter int LOCK = 0,
  parameter int IDX  = $clog2(PORT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PORT-1:0]      in_valid,
  output logic [PORT-1:0]      in_ready,
  input  logic [PORT-1:0]      in_last,
  input  logic [PORT*DATA-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA-1:0]      out_data,
  output logic [IDX-1:0]       out_port,
  output logic                 out_last
);

  lock_state_e     state;
  logic [IDX-1:0]  lock_port;
  logic [IDX-1:0]  grant_idx;
  logic [IDX-1:0]  xfer_idx;
  logic [PORT-1:0] granto;
  logic [PORT-1:0] lock_mask;
  logic [DATA-1:0] xfer_data;
  logic            xfer_last;
  logic            accept;
  logic            locked;
  logic            xfer;

  assign accept = !out_valid || out_ready;
  assign locked = (state == ST_LOCKED);

  rr_arbiter #(.PORT(PORT), .IDX(IDX)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (in_valid),
    .stall  (!accept || locked),
    .granto (granto)
  );

  always_comb begin
    grant_idx = '0;
    lock_mask = '0;
    for (int k = 0; k < PORT; k++) begin
      if (granto[k]) grant_idx = IDX'(k);
      lock_mask[k] = (lock_port == IDX'(k)) && accept;
    end
  end

  assign in_ready = reset ? '0 : (locked ? lock_mask : granto);
  assign xfer     = |(in_valid & in_ready);
  assign xfer_idx = locked ? lock_port : grant_idx;

  always_comb begin
    xfer_data = '0;
    xfer_last = 1'b0;
    for (int k = 0; k < PORT; k++) begin
      if (xfer_idx == IDX'(k)) begin
        xfer_data = in_data[k*DATA +: DATA];
        xfer_last = in_last[k];
      end
    end
  end

  // A new accept overrides the drain, so drain and refill share a cycle without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= ZERO;
      out_data  <= '0;
      out_port  <= '0;
      out_last  <= ZERO;
    end else if (xfer) begin
      out_valid <= ONE;
      out_data  <= xfer_data;
      out_port  <= xfer_idx;
      out_last  <= (LOCK != 0) ? xfer_last : ZERO;
    end else if (out_ready) begin
      out_valid <= ZERO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      lock_port <= '0;
    end else if ((LOCK != 0) && xfer) begin
      case (state)
        ST_IDLE: begin
          if (!xfer_last) begin
            state     <= ST_LOCKED;
            lock_port <= grant_idx;
          end
        end
        ST_LOCKED: begin
          if (xfer_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - table-driven scoreboard bench for arb_mux (PORT=4, PORT=3, LOCK=1)
module tb_arb_mux;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [1:0] exp_port;
  } vec_t;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]   a_valid, a_ready, a_last;
  logic [127:0] a_data;
  logic         a_ordy, a_ov, a_olast;
  logic [31:0]  a_odata;
  logic [1:0]   a_oport;

  logic [2:0]   b_valid, b_ready, b_last;
  logic [95:0]  b_data;
  logic         b_ordy, b_ov, b_olast;
  logic [31:0]  b_odata;
  logic [1:0]   b_oport;

  logic [3:0]   c_valid, c_ready, c_last;
  logic [127:0] c_data;
  logic         c_ordy, c_ov, c_olast;
  logic [31:0]  c_odata;
  logic [1:0]   c_oport;

  arb_mux #(.PORT(4), .DATA(32), .LOCK(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready), .in_last(a_last),
    .in_data(a_data), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_odata),
    .out_port(a_oport), .out_last(a_olast));

  arb_mux #(.PORT(3), .DATA(32), .LOCK(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready), .in_last(b_last),
    .in_data(b_data), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_odata),
    .out_port(b_oport), .out_last(b_olast));

  arb_mux #(.PORT(4), .DATA(32), .LOCK(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_valid), .in_ready(c_ready), .in_last(c_last),
    .in_data(c_data), .out_valid(c_ov), .out_ready(c_ordy), .out_data(c_odata),
    .out_port(c_oport), .out_last(c_olast));

  int    tests = 0;
  int    fails = 0;
  beat_t sb_q[$];
  vec_t  tab_a[15];
  vec_t  tab_b[6];
  vec_t  tab_c[10];
  vec_t  tab_r[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int dut, input int r, input vec_t v);
    logic [31:0] d [4];
    logic [3:0]  rdy;
    logic        ov, olast;
    logic [1:0]  oport;
    logic [31:0] odata;
    beat_t       b, e;
    @(negedge clk);
    for (int k = 0; k < 4; k++) d[k] = (32'(dut) << 16) | (32'(r) << 8) | (32'h10 + 32'(k));
    case (dut)
      0: begin a_valid = v.valid; a_last = v.last; a_ordy = v.ordy; a_data = {d[3], d[2], d[1], d[0]}; end
      1: begin b_valid = v.valid[2:0]; b_last = v.last[2:0]; b_ordy = v.ordy; b_data = {d[2], d[1], d[0]}; end
      default: begin c_valid = v.valid; c_last = v.last; c_ordy = v.ordy; c_data = {d[3], d[2], d[1], d[0]}; end
    endcase
    #1;
    case (dut)
      0: begin rdy = a_ready; ov = a_ov; oport = a_oport; odata = a_odata; olast = a_olast; end
      1: begin rdy = {1'b0, b_ready}; ov = b_ov; oport = b_oport; odata = b_odata; olast = b_olast; end
      default: begin rdy = c_ready; ov = c_ov; oport = c_oport; odata = c_odata; olast = c_olast; end
    endcase
    check($sformatf("in_ready d%0d r%0d", dut, r), 32'(rdy), 32'(v.exp_ready));
    check($sformatf("out_valid d%0d r%0d", dut, r), 32'(ov), 32'(v.exp_ov));
    if (v.exp_ov) check($sformatf("out_port d%0d r%0d", dut, r), 32'(oport), 32'(v.exp_port));
    if (ov && v.ordy) begin
      if (sb_q.size() == 0) begin
        check($sformatf("sb_underflow d%0d r%0d", dut, r), 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check($sformatf("beat_port d%0d r%0d", dut, r), 32'(oport), 32'(e.port));
        check($sformatf("beat_data d%0d r%0d", dut, r), odata, e.data);
        check($sformatf("beat_last d%0d r%0d", dut, r), 32'(olast), 32'(e.last));
      end
    end
    if ((v.exp_ready & v.valid) != 4'b0000) begin
      b.port = 2'd0;
      for (int k = 0; k < 4; k++) if (v.exp_ready[k]) b.port = 2'(k);
      b.data = d[b.port];
      b.last = (dut == 2) ? v.last[b.port] : 1'b0;
      sb_q.push_back(b);
    end
  endtask

  initial begin
    tab_a[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0};
    tab_a[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0};
    tab_a[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd1};
    tab_a[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd2};
    tab_a[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd3};
    tab_a[5]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};
    tab_a[6]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};
    tab_a[7]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};
    tab_a[8]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0};
    tab_a[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
    tab_a[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tab_a[11] = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0};
    tab_a[12] = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd2};
    tab_a[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
    tab_a[14] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};

    tab_b[0]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0};
    tab_b[1]  = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd0};
    tab_b[2]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd2};
    tab_b[3]  = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd0};
    tab_b[4]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
    tab_b[5]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    tab_c[0]  = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b0, 2'd0};
    tab_c[1]  = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1, 2'd1};
    tab_c[2]  = '{4'b0110, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
    tab_c[3]  = '{4'b0110, 4'b0110, 1'b1, 4'b0100, 1'b1, 2'd1};
    tab_c[4]  = '{4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd2};
    tab_c[5]  = '{4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd0};
    tab_c[6]  = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd1};
    tab_c[7]  = '{4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};
    tab_c[8]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3};
    tab_c[9]  = '{4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};

    tab_r[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tab_r[1]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    tab_r[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    reset = 1'b1;
    a_valid = 4'hf; a_last = '0; a_data = '0; a_ordy = 1'b1;
    b_valid = 3'h7; b_last = '0; b_data = '0; b_ordy = 1'b1;
    c_valid = 4'hf; c_last = '0; c_data = '0; c_ordy = 1'b1;
    repeat (2) @(negedge clk);
    check("reset in_ready a", 32'(a_ready), 32'(0));
    check("reset in_ready b", 32'(b_ready), 32'(0));
    check("reset in_ready c", 32'(c_ready), 32'(0));
    a_valid = '0; b_valid = '0; c_valid = '0;
    reset = 1'b0;
    #1;
    check("reset out_valid a", 32'(a_ov), 32'(0));
    check("reset out_data a", a_odata, 32'(0));
    check("reset out_port a", 32'(a_oport), 32'(0));
    check("reset out_last c", 32'(c_olast), 32'(0));
    check("reset out_valid c", 32'(c_ov), 32'(0));

    for (int r = 0; r < 15; r++) apply(0, r, tab_a[r]);
    check("sb_empty a", 32'(sb_q.size()), 32'(0));
    sb_q.delete();
    a_valid = '0;

    for (int r = 0; r < 6; r++) apply(1, r, tab_b[r]);
    check("sb_empty b", 32'(sb_q.size()), 32'(0));
    sb_q.delete();
    b_valid = '0;

    for (int r = 0; r < 10; r++) apply(2, r, tab_c[r]);

    // Reset while locked with a beat held: the beat and the lock are discarded.
    @(negedge clk);
    reset = 1'b1; c_valid = 4'b1001; c_ordy = 1'b0;
    #1;
    check("midreset in_ready c", 32'(c_ready), 32'(0));
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0; c_valid = '0;
    #1;
    check("midreset out_valid c", 32'(c_ov), 32'(0));
    for (int r = 0; r < 3; r++) apply(2, 20 + r, tab_r[r]);
    check("sb_empty c", 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
